// File: rtl/prirv32_bus_arbiter_if.sv
// Bus bundle between the IFU/EXU requesters, the arbiter and the memory port.
// The master view is the arbiter; the slave view is the surrounding requesters and memory.
interface prirv32_bus_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    modport master (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/prirv32_bus_arbiter.sv
// Fetch/data arbiter onto a single memory port: one outstanding transaction, data priority
// bounded by a streak counter, and a response watchdog that turns a hung memory into an error.
module prirv32_bus_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    prirv32_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;

    localparam logic [3:0] StreakMax   = 4'(STREAK_MAX);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e      state;
    logic        owner_data;
    logic [3:0]  streak;
    logic [7:0]  wdog;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        pick_data;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always_comb begin
        pick_data = bus.d_req_i && !(bus.if_req_i && (streak == StreakMax));
        gnt       = (state == StAddr) && bus.mem_gnt_i;
        // A real response in the last watchdog cycle beats the timeout.
        rvalid    = (state == StResp) && (bus.mem_rvalid_i || (wdog == TimeoutLast));
        rdata     = bus.mem_rvalid_i ? bus.mem_rdata_i : 32'h0;
        err       = bus.mem_rvalid_i ? bus.mem_err_i : 1'b1;

        bus.if_gnt_o    = gnt && !owner_data;
        bus.if_rvalid_o = rvalid && !owner_data;
        bus.if_rdata_o  = (rvalid && !owner_data) ? rdata : 32'h0;
        bus.if_err_o    = rvalid && !owner_data && err;
        bus.d_gnt_o     = gnt && owner_data;
        bus.d_rvalid_o  = rvalid && owner_data;
        bus.d_rdata_o   = (rvalid && owner_data) ? rdata : 32'h0;
        bus.d_err_o     = rvalid && owner_data && err;

        bus.mem_req_o   = mem_req;
        bus.mem_we_o    = mem_we;
        bus.mem_be_o    = mem_be;
        bus.mem_addr_o  = mem_addr;
        bus.mem_wdata_o = mem_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            owner_data <= 1'b0;
            streak     <= 4'd0;
            wdog       <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.if_req_i || bus.d_req_i) begin
                        state      <= StAddr;
                        mem_req    <= 1'b1;
                        owner_data <= pick_data;
                        if (pick_data) begin
                            mem_we    <= bus.d_we_i;
                            mem_be    <= bus.d_be_i;
                            mem_addr  <= bus.d_addr_i;
                            mem_wdata <= bus.d_wdata_i;
                            // Data can only win a contested slot below StreakMax,
                            // so the increment saturates by construction.
                            streak    <= bus.if_req_i ? streak + 4'd1 : 4'd0;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= 4'hF;
                            mem_addr  <= bus.if_addr_i;
                            mem_wdata <= 32'h0;
                            streak    <= 4'd0;
                        end
                    end
                end
                StAddr: begin
                    if (bus.mem_gnt_i) begin
                        state   <= StResp;
                        mem_req <= 1'b0;
                        wdog    <= 8'd0;
                    end
                end
                StResp: begin
                    if (bus.mem_rvalid_i || (wdog == TimeoutLast)) begin
                        state <= StIdle;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_prirv32_bus_arbiter.sv
// Self-checking bench for prirv32_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_prirv32_bus_arbiter;
    localparam int SMAX = 4;
    localparam int TMO  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prirv32_bus_arbiter_if bus ();

    prirv32_bus_arbiter #(
        .STREAK_MAX(SMAX),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i(clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: phase 0 = no transaction, 1 = address offered, 2 = awaiting response.
    int          mph;
    bit          m_dat;
    int          m_streak;
    int          m_wait;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;

    bit          saw_ig;
    bit          saw_dg;
    bit          pend_i;
    bit          pend_d;
    bit          outst;
    int          rcnt;
    int          ng;
    logic [9:0]  order;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mph = 0; m_dat = 1'b0; m_streak = 0; m_wait = 0;
        m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    endtask

    task automatic idle_inputs();
        bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_be_i = 4'h0;
        bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i = 32'h0; bus.mem_err_i = 1'b0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_reset();
            return;
        end
        case (mph)
            0: if (bus.if_req_i || bus.d_req_i) begin
                m_dat = bus.d_req_i && !(bus.if_req_i && m_streak == SMAX);
                if (m_dat) begin
                    m_streak = bus.if_req_i ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
                    m_we = bus.d_we_i; m_be = bus.d_be_i;
                    m_addr = bus.d_addr_i; m_wdata = bus.d_wdata_i;
                end else begin
                    m_streak = 0;
                    m_we = 1'b0; m_be = 4'hF; m_addr = bus.if_addr_i; m_wdata = 32'h0;
                end
                mph = 1;
            end
            1: if (bus.mem_gnt_i) begin
                mph = 2; m_wait = 0;
            end
            default: if (bus.mem_rvalid_i) begin
                mph = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) mph = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        bit          g;
        bit          rv;
        logic [31:0] rd;
        bit          er;
        g  = (mph == 1) && bus.mem_gnt_i;
        rv = (mph == 2) && (bus.mem_rvalid_i || (m_wait + 1 == TMO));
        rd = bus.mem_rvalid_i ? bus.mem_rdata_i : 32'h0;
        er = bus.mem_rvalid_i ? bus.mem_err_i : 1'b1;
        chk("if_gnt",    32'(bus.if_gnt_o),    32'(g && !m_dat));
        chk("d_gnt",     32'(bus.d_gnt_o),     32'(g && m_dat));
        chk("if_rvalid", 32'(bus.if_rvalid_o), 32'(rv && !m_dat));
        chk("d_rvalid",  32'(bus.d_rvalid_o),  32'(rv && m_dat));
        chk("if_rdata",  bus.if_rdata_o,       (rv && !m_dat) ? rd : 32'h0);
        chk("d_rdata",   bus.d_rdata_o,        (rv && m_dat) ? rd : 32'h0);
        chk("if_err",    32'(bus.if_err_o),    32'(rv && !m_dat && er));
        chk("d_err",     32'(bus.d_err_o),     32'(rv && m_dat && er));
        chk("mem_req",   32'(bus.mem_req_o),   32'(mph == 1));
        chk("mem_we",    32'(bus.mem_we_o),    32'(m_we));
        chk("mem_be",    32'(bus.mem_be_o),    32'(m_be));
        chk("mem_addr",  bus.mem_addr_o,       m_addr);
        chk("mem_wdata", bus.mem_wdata_o,      m_wdata);
    endtask

    task automatic cyc();
        #2;
        compare_all();
        saw_ig = bus.if_gnt_o;
        saw_dg = bus.d_gnt_o;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive_random();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            m_reset();
        end
        if (saw_ig) pend_i = 1'b0;
        if (saw_dg) pend_d = 1'b0;
        if (!pend_i && $urandom_range(0, 2) == 0) begin
            pend_i = 1'b1;
            bus.if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d = 1'b1;
            bus.d_we_i = 1'($urandom_range(0, 1));
            bus.d_be_i = 4'($urandom_range(0, 15));
            bus.d_addr_i = $urandom;
            bus.d_wdata_i = $urandom;
        end
        bus.if_req_i = pend_i;
        bus.d_req_i = pend_d;
        bus.mem_gnt_i = ($urandom_range(0, 1) == 0);
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0; bus.mem_err_i = 1'b0;
        if (mph == 2) begin
            // Delays of TMO or more leave the memory silent until the watchdog fires.
            if (!outst) begin
                outst = 1'b1;
                rcnt = $urandom_range(0, TMO + 2);
            end
            if (rcnt == 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i = $urandom;
                bus.mem_err_i = ($urandom_range(0, 7) == 0);
            end else begin
                rcnt--;
            end
        end else begin
            outst = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i = $urandom;
                bus.mem_err_i = 1'($urandom_range(0, 1));
            end
        end
    endtask

    initial begin
        idle_inputs();
        m_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req",   32'(bus.mem_req_o),   32'h0);
        chk("rst_mem_be",    32'(bus.mem_be_o),    32'h0);
        chk("rst_mem_addr",  bus.mem_addr_o,       32'h0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
        chk("rst_d_gnt",     32'(bus.d_gnt_o),     32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch only, zero-wait memory.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
        cyc();
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t1_mem_req",  32'(bus.mem_req_o), 32'h1);
        chk("t1_if_gnt",   32'(bus.if_gnt_o),  32'h1);
        chk("t1_mem_be",   32'(bus.mem_be_o),  32'hF);
        chk("t1_mem_we",   32'(bus.mem_we_o),  32'h0);
        chk("t1_mem_addr", bus.mem_addr_o,     32'h100);
        cyc();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        #1;
        chk("t1_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("t1_if_rdata",  bus.if_rdata_o,       32'hDEADBEEF);
        chk("t1_if_err",    32'(bus.if_err_o),    32'h0);
        cyc();
        idle_inputs();
        cyc();

        // Both requesting continuously: four data grants, then one fetch.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h204;
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h308; bus.d_be_i = 4'hF;
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5;
        order = 10'h0; ng = 0;
        for (int i = 0; i < 60 && ng < 10; i++) begin
            #1;
            if (bus.d_gnt_o) begin
                order = {order[8:0], 1'b1}; ng++;
            end else if (bus.if_gnt_o) begin
                order = {order[8:0], 1'b0}; ng++;
            end
            cyc();
        end
        chk("t2_grant_count", 32'(ng),    32'd10);
        chk("t2_grant_order", 32'(order), 32'h3DE);
        bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
        cyc();
        idle_inputs();
        cyc();

        // Data write with a three-cycle grant stall.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
        bus.d_addr_i = 32'h20; bus.d_wdata_i = 32'h1234;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_mem_req",   32'(bus.mem_req_o), 32'h1);
            chk("t3_mem_addr",  bus.mem_addr_o,     32'h20);
            chk("t3_mem_be",    32'(bus.mem_be_o),  32'h3);
            chk("t3_mem_we",    32'(bus.mem_we_o),  32'h1);
            chk("t3_mem_wdata", bus.mem_wdata_o,    32'h1234);
            chk("t3_d_gnt",     32'(bus.d_gnt_o),   32'h0);
            cyc();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t3_mem_req4", 32'(bus.mem_req_o), 32'h1);
        chk("t3_d_gnt4",   32'(bus.d_gnt_o),   32'h1);
        cyc();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        cyc();
        idle_inputs();
        cyc();

        // Data read that never gets a response while a fetch waits.
        bus.d_req_i = 1'b1; bus.d_addr_i = 32'h40; bus.d_be_i = 4'hF;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
        cyc();
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t4_d_gnt", 32'(bus.d_gnt_o), 32'h1);
        cyc();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("t4_d_rvalid", 32'(bus.d_rvalid_o), 32'(i == 5));
            chk("t4_d_err",    32'(bus.d_err_o),    32'(i == 5));
            chk("t4_d_rdata",  bus.d_rdata_o,       32'h0);
            cyc();
        end
        cyc();
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t4_if_gnt",  32'(bus.if_gnt_o),  32'h1);
        chk("t4_mem_addr", bus.mem_addr_o,    32'h200);
        cyc();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE0001;
        #1;
        chk("t4_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("t4_if_err",    32'(bus.if_err_o),    32'h0);
        chk("t4_if_rdata",  bus.if_rdata_o,       32'hCAFE0001);
        cyc();
        idle_inputs();
        cyc();

        // Fetch answered with a bus error.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
        cyc();
        bus.mem_gnt_i = 1'b1;
        cyc();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0;
        bus.mem_rvalid_i = 1'b1; bus.mem_err_i = 1'b1; bus.mem_rdata_i = 32'h77;
        #1;
        chk("t5_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
        chk("t5_if_err",    32'(bus.if_err_o),    32'h1);
        chk("t5_if_rdata",  bus.if_rdata_o,       32'h77);
        cyc();
        idle_inputs();
        cyc();

        // Build a full data streak, reset mid-response, then data must win again.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h400;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'hF;
        bus.d_addr_i = 32'h80; bus.d_wdata_i = 32'h99;
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h55;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            if (bus.d_gnt_o) ng++;
            cyc();
        end
        chk("t6_d_grants", 32'(ng), 32'd4);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t6_rst_d_rvalid", 32'(bus.d_rvalid_o), 32'h0);
        chk("t6_rst_d_rdata",  bus.d_rdata_o,       32'h0);
        chk("t6_rst_mem_addr", bus.mem_addr_o,      32'h0);
        chk("t6_rst_mem_be",   32'(bus.mem_be_o),   32'h0);
        chk("t6_rst_mem_we",   32'(bus.mem_we_o),   32'h0);
        chk("t6_rst_mem_wdata", bus.mem_wdata_o,    32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        chk("t6_post_d_gnt",  32'(bus.d_gnt_o),  32'h1);
        chk("t6_post_if_gnt", 32'(bus.if_gnt_o), 32'h0);
        cyc();
        bus.if_req_i = 1'b0; bus.d_req_i = 1'b0;
        cyc();
        idle_inputs();
        cyc();

        // Randomized traffic.
        pend_i = 1'b0; pend_d = 1'b0; outst = 1'b0; rcnt = 0;
        saw_ig = 1'b0; saw_dg = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prirv32_bus_arbiter.md
# prirv32_bus_arbiter

Two-requester, single-port memory arbiter for the priRV32 core. It shares one memory bus between instruction fetch (IFU) and load/store (EXU). It sits between those units and the memory port in the core top level. One transaction is outstanding at a time. Data has fixed priority, bounded by an anti-starvation streak counter, and a response watchdog converts a hung memory into an error response.

## Interface
Parameters:
- STREAK_MAX, 4: max consecutive data grants while fetch waits (1..15)
- TIMEOUT, 255: max cycles in RESP before error response (1..255)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req_i  in  1  fetch request; held with address until if_gnt_o
- if_addr_i  in  32  fetch word address
- if_gnt_o  out  1  fetch address accepted (single-cycle)
- if_rvalid_o  out  1  fetch response valid (single-cycle)
- if_rdata_o  out  32  fetch read data, valid with if_rvalid_o
- if_err_o  out  1  fetch bus/timeout error, valid with if_rvalid_o
- d_req_i  in  1  data request; held with fields until d_gnt_o
- d_we_i  in  1  1 = write
- d_be_i  in  4  byte enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  write data
- d_gnt_o, d_rvalid_o, d_err_o  out  1  as fetch equivalents
- d_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable (0 for fetch)
- mem_be_o  out  4  byte enables (4'hF for fetch)
- mem_addr_o, mem_wdata_o  out  32  latched address / write data (wdata 0 for fetch)
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- mem_err_i  in  1  memory error, valid with mem_rvalid_i

## Operation
- FSM states and transitions:
  - IDLE: if either request is high, pick an owner, latch its fields into mem_* registers and go to ADDR.
  - ADDR: mem_req_o=1. On mem_gnt_i, go to RESP and clear the watchdog.
  - RESP: on mem_rvalid_i, go to IDLE. Otherwise increment the watchdog; when it reaches TIMEOUT, go to IDLE and issue an error response.
- Arbitration in IDLE:
  - Only d_req_i high: data wins.
  - Only if_req_i high: fetch wins.
  - Both high: data wins unless streak==STREAK_MAX, in which case fetch wins.
- Streak counter (4-bit):
  - Increments on a data grant while if_req_i=1.
  - Clears on a fetch grant, or on a data grant while if_req_i=0.
  - Saturates at STREAK_MAX.
- Grant: owner's gnt_o = mem_gnt_i in ADDR (combinational). Non-owner gnt_o = 0.
- Normal response in RESP: owner rvalid_o = mem_rvalid_i, with rdata_o = mem_rdata_i and err_o = mem_err_i (combinational).
- Timeout response: owner rvalid_o=1, err_o=1, rdata_o=0 for exactly the cycle the watchdog equals TIMEOUT.
- Non-owner rvalid_o/rdata_o/err_o are always 0.
- mem_rvalid_i arriving in IDLE or ADDR is discarded. Late responses after a timeout are lost; the system guarantees memory never answers a timed-out request.
- Requester fields are sampled only at the arbitration edge. Changes afterwards do not affect the bus.

## Timing
- Reset values: state=IDLE, streak=0, watchdog=0, owner=fetch. All outputs are 0, including mem_be_o=0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately (asynchronous) and the outstanding transaction is abandoned without a response.
- Latency:
  - Request high before edge E → mem_req_o high in the cycle after E.
  - With zero-wait memory: gnt in cycle E+1, rvalid earliest in E+2.
  - Next arbitration at the edge ending the rvalid cycle.
  - Minimum 3 cycles per transaction.
- mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o stay stable from the arbitration edge until leaving RESP. They hold their last value in IDLE; mem_req_o is 0 outside ADDR.
- mem_gnt_i and mem_rvalid_i in the same cycle: ADDR consumes only the grant; the response must come in a later cycle.
- Watchdog:
  - 8-bit, counts RESP cycles without rvalid.
  - mem_rvalid_i in the same cycle the count hits TIMEOUT wins: a normal response, no error.

## Test plan
- Only if_req_i, addr 0x100, memory gnt immediate, rvalid one cycle later with data 0xDEADBEEF → mem_req_o cycle 1, if_gnt_o cycle 1, if_rvalid_o cycle 2 with rdata 0xDEADBEEF, if_err_o=0, mem_be_o=4'hF, mem_we_o=0.
- Both request continuously, STREAK_MAX=4 → grant order D,D,D,D,F,D,D,D,D,F; d_gnt_o never asserted while fetch owns.
- Data write, addr 0x20, be 4'b0011, wdata 0x1234; mem_gnt_i delayed 3 cycles → mem_req_o held 4 cycles with fields stable; d_gnt_o only in the 4th.
- Memory never returns rvalid, TIMEOUT=5 → d_rvalid_o=1, d_err_o=1, d_rdata_o=0 in the 5th RESP cycle; the FSM then serves a pending fetch normally.
- mem_err_i=1 with rvalid on a fetch → if_err_o=1 for that cycle; streak unchanged by the error.
- rst_n low during RESP → all outputs 0 at once; after release, a new request is arbitrated from IDLE with streak=0.
